bcd_display_feeder: RTL
=======================

Name: bcd_display_feeder

Overview:
Upstream stage of the 4-digit hex/TM1637 display path. Accepts a binary value (0..9999) over a valid/ready handshake and converts it to packed 4-digit BCD with a sequential shift-add-3 (double dabble). When the display stage reports not busy, it presents the BCD word and pulses its latch. Enforces a minimum refresh interval so fast producers cannot saturate the serial display link.

Parameters:
BIN_W, 14, width of the binary input. Must be at least 14 so that 9999 is representable.
REFRESH_CYCLES, 1000000, minimum number of clk cycles from one disp_latch pulse to the next value acceptance. Must be at least 2.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
value_valid  input  1  producer has a value on value_in
value_in  input  BIN_W  unsigned binary value
value_ready  output  1  block can accept a value this cycle
disp_busy  input  1  busy from the display stage
disp_latch  output  1  one-cycle pulse; the display stage loads disp_data
disp_data  output  16  packed BCD: [15:12] thousands … [3:0] units
overflow  output  1  last accepted value exceeded 9999

Behaviour:
- Reset: state=IDLE, value_ready=1, disp_latch=0, disp_data=16'h0000, overflow=0, holdoff counter=0. Reset takes effect at the next edge from any state, including mid-conversion and mid-holdoff. No latch pulse is produced after reset.
- All outputs are registered. value_ready is 1 only in IDLE.
- States: IDLE, CONVERT, WAIT_DISP, HOLDOFF.
- IDLE:
  - On value_valid && value_ready, capture value_in.
  - If value_in > 9999, load 9999 and set overflow=1. Otherwise load value_in and clear overflow.
  - Clear the 16-bit BCD accumulator, set the bit counter to BIN_W, and go to CONVERT.
  - value_valid while not ready is ignored; the producer must hold it.
- CONVERT: one bit per cycle, exactly BIN_W cycles.
  - Each nibble ≥5 gets +3.
  - Then {bcd, bin} shifts left by 1.
  - When the counter reaches 0, go to WAIT_DISP.
- WAIT_DISP:
  - If disp_busy=0: register disp_data<=bcd, pulse disp_latch=1 for the following cycle, load the holdoff counter with REFRESH_CYCLES-1, and go to HOLDOFF.
  - If disp_busy=1: stay, waiting indefinitely.
- Latency: with disp_busy low, disp_latch is high in cycle BIN_W+2 after the accepting edge (16 for the default).
- HOLDOFF:
  - disp_latch returns to 0 after exactly one cycle.
  - Decrement the counter each cycle; at 0, go to IDLE.
  - disp_busy is ignored here. This covers the one-cycle lag of the display stage's registered busy.
- disp_data is stable from the latch edge until the next latch. The display stage samples it over many cycles while busy.
- disp_latch is never asserted while disp_busy=1.
- overflow changes only on acceptance.

Decomposition:
- Shared package: state encoding, BCD_DIGITS=4, MAX_VALUE=14'd9999, the add-3 threshold constant.
- One natural sub-module: bin_to_bcd_seq.
  - Ports: start, bin_in, busy, done, bcd_out.
  - Sequential double dabble that holds the CONVERT state and bit counter.
  - The top module keeps the handshake, saturation, the display-side FSM and the holdoff counter.

Test Plan:
- Accept 1234 with disp_busy=0 -> disp_latch pulses once, 16 cycles after acceptance; disp_data=16'h1234; overflow=0.
- Accept 0, then 9999 (REFRESH_CYCLES=20) -> disp_data=16'h0000, then 16'h9999. value_ready stays low until 19 cycles after the first latch pulse.
- Accept 12000 -> disp_data=16'h9999, overflow=1. A later 42 gives 16'h0042 and overflow=0.
- Hold disp_busy=1 for 50 cycles after conversion -> no disp_latch while busy. The latch pulses one cycle after disp_busy falls; disp_data changes only then.
- Assert value_valid continuously with a changing value_in -> exactly one latch per REFRESH_CYCLES window. Each latched value is the one sampled when ready was high.
- Assert rst in the 5th CONVERT cycle of 5678 -> no latch pulse; disp_data=16'h0000; value_ready=1 the next cycle. A following 5678 converts correctly.

Source files
------------

// File: rtl/bcd_display_feeder_pkg.sv
// bcd_display_feeder_pkg: shared states, BCD constants and the add-3 helper.
package bcd_display_feeder_pkg;
  typedef enum logic [1:0] {IDLE, CONVERT, WAIT_DISP, HOLDOFF} state_t;
  localparam int BCD_DIGITS = 4;
  localparam int BCD_W = 4 * BCD_DIGITS;
  localparam logic [13:0] MAX_VALUE = 14'd9999;
  localparam logic [3:0] ADD3_THRESH = 4'd5;
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int k = 0; k < BCD_DIGITS; k++)
      r[4*k+:4] = b[4*k+:4] + ((b[4*k+:4] >= ADD3_THRESH) ? 4'd3 : 4'd0);
    return r;
  endfunction
endpackage

// File: rtl/bcd_display_feeder_bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double dabble, one input bit per cycle.
module bin_to_bcd_seq
  import bcd_display_feeder_pkg::*;
#(
  parameter int BIN_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [BIN_W-1:0] i_bin_in,
  output logic             o_busy,
  output logic             o_done,
  output logic [BCD_W-1:0] o_bcd_out
);
  localparam int CW = $clog2(BIN_W + 1);
  logic [BIN_W-1:0] r_bin;
  logic [BCD_W-1:0] r_bcd;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [BCD_W-1:0] w_adj;
  assign w_adj = add3(r_bcd);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_bin  <= i_bin_in;
        r_bcd  <= '0;
        r_cnt  <= CW'(BIN_W);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_bcd <= {w_adj[BCD_W-2:0], r_bin[BIN_W-1]};
        r_bin <= r_bin << 1;
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == CW'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_bcd_out = r_bcd;
endmodule

// File: rtl/bcd_display_feeder.sv
// bcd_display_feeder: accepts binary values, converts to BCD and feeds the display
// stage with a latch pulse, rate-limited by a refresh holdoff.
module bcd_display_feeder
  import bcd_display_feeder_pkg::*;
#(
  parameter int BIN_W          = 14,
  parameter int REFRESH_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_value_valid,
  input  logic [BIN_W-1:0] i_value_in,
  output logic             o_value_ready,
  input  logic             i_disp_busy,
  output logic             o_disp_latch,
  output logic [BCD_W-1:0] o_disp_data,
  output logic             o_overflow
);
  localparam int HW = $clog2(REFRESH_CYCLES);
  state_t           r_state, w_next;
  logic [HW-1:0]    r_hold;
  logic             w_accept, w_sat, w_busy, w_done, w_fire;
  logic [BIN_W-1:0] w_bin;
  logic [BCD_W-1:0] w_bcd;
  assign w_accept = (r_state == IDLE) && i_value_valid;
  assign w_sat    = i_value_in > BIN_W'(MAX_VALUE);
  assign w_bin    = w_sat ? BIN_W'(MAX_VALUE) : i_value_in;
  assign w_fire   = (r_state == WAIT_DISP) && !i_disp_busy;
  bin_to_bcd_seq #(.BIN_W(BIN_W)) u_conv (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_accept),
    .i_bin_in (w_bin),
    .o_busy   (w_busy),
    .o_done   (w_done),
    .o_bcd_out(w_bcd)
  );
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:      w_next = i_value_valid ? CONVERT : IDLE;
      CONVERT:   w_next = (w_done && !w_busy) ? WAIT_DISP : CONVERT;
      WAIT_DISP: w_next = i_disp_busy ? WAIT_DISP : HOLDOFF;
      HOLDOFF:   w_next = (r_hold <= HW'(1)) ? IDLE : HOLDOFF;
      default:   w_next = IDLE;
    endcase
  end
  // ready for acceptance exactly REFRESH_CYCLES edges after the latch edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      o_value_ready <= 1'b1;
      o_disp_latch  <= 1'b0;
      o_disp_data   <= '0;
      o_overflow    <= 1'b0;
      r_hold        <= '0;
    end else begin
      r_state       <= w_next;
      o_value_ready <= (w_next == IDLE);
      o_disp_latch  <= w_fire;
      if (w_fire) begin
        o_disp_data <= w_bcd;
        r_hold      <= HW'(REFRESH_CYCLES - 1);
      end else if (r_state == HOLDOFF) begin
        r_hold <= r_hold - 1'b1;
      end
      if (w_accept) o_overflow <= w_sat;
    end
  end
endmodule
